ahb_default_slave_v2: RTL and testbench

Parametrised next-generation AHB default slave that terminates transfers to unmapped addresses.
- Generates the spec-compliant two-cycle ERROR response, with optional programmable wait states before it.
- Alternative RAZ/WI (OKAY) mode.
- Fault logging for software and debug: saturating access counter, first-fault address/master/direction capture.
- Sits behind the decoder's HSEL_DEFAULT; outputs feed the slave-to-master response mux.

---
 rtl/ahb_params_pkg.sv | 35 +++
 rtl/ahb_fault_logger.sv | 62 ++++++
 rtl/ahb_default_slave_v2.sv | 122 ++++++++++++
 tb/tb_ahb_default_slave_v2.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_params_pkg.sv
// Shared AHB bus types and default widths, plus the default-slave FSM
// state encoding.
package ahb_params_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 32;
  localparam int NO_OF_MASTERS = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } dflt_state_t;

  // Width of a master ID; a single-master bus still gets a 1-bit field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ahb_fault_logger.sv
// Fault logger: saturating access counter plus first-fault capture of
// address, master and direction. Shared with the APB bridge.
module ahb_fault_logger #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ID_WIDTH-1:0]   master,
  input  logic                  write,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ID_WIDTH-1:0]   err_master,
  output logic                  err_write,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // A clear in the same cycle as an accept makes this fault the new "first".
  logic capture;
  assign capture = accept && (!err_valid || clear);

  // Counter and valid flag; a coincident accept takes priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_valid <= 1'b0;
    end else if (accept) begin
      err_valid <= 1'b1;
      if (clear) begin
        err_count <= CNT_ONE;
      end else if (err_count != CNT_MAX) begin
        err_count <= err_count + CNT_ONE;
      end
    end else if (clear) begin
      err_count <= '0;
      err_valid <= 1'b0;
    end
  end

  // First-fault capture; clear alone leaves the last capture in place.
  // NOTE: these are plain registers, not a memory, and software reads them,
  // so they get an explicit reset value instead of powering up unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr   <= '0;
      err_master <= '0;
      err_write  <= 1'b0;
    end else if (capture) begin
      err_addr   <= addr;
      err_master <= master;
      err_write  <= write;
    end
  end

endmodule

// File: rtl/ahb_default_slave_v2.sv
// AHB default slave: terminates transfers to unmapped space with a two-cycle
// ERROR (or RAZ/WI OKAY), optional wait states, and fault logging.
module ahb_default_slave_v2 #(
  parameter int                                         DATA_WIDTH    = ahb_params_pkg::DATA_WIDTH,
  parameter int                                         ADDR_WIDTH    = ahb_params_pkg::ADDR_WIDTH,
  parameter int                                         NO_OF_MASTERS = ahb_params_pkg::NO_OF_MASTERS,
  parameter int                                         WAIT_STATES   = 0,
  parameter int                                         RESP_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0]                      DEFAULT_RDATA = '0,
  parameter int                                         CNT_WIDTH     = 16
) (
  input  logic                                                HCLK,
  input  logic                                                HRESET,
  input  logic                                                HSEL_DEFAULT,
  input  logic [1:0]                                          HTRANS,
  input  logic [ADDR_WIDTH-1:0]                               HADDR,
  input  logic                                                HWRITE,
  input  logic [ahb_params_pkg::id_width(NO_OF_MASTERS)-1:0]  HMASTER,
  input  logic                                                HREADY,
  output logic [DATA_WIDTH-1:0]                               hrdata_default,
  output logic                                                hready_default,
  output logic [1:0]                                          hresp_default,
  output logic [NO_OF_MASTERS-1:0]                            hsplit_default,
  input  logic                                                err_clear,
  output logic                                                err_valid,
  output logic [ADDR_WIDTH-1:0]                               err_addr,
  output logic [ahb_params_pkg::id_width(NO_OF_MASTERS)-1:0]  err_master,
  output logic                                                err_write,
  output logic [CNT_WIDTH-1:0]                                err_count
);

  import ahb_params_pkg::*;

  localparam int         MASTER_ID_W = id_width(NO_OF_MASTERS);
  localparam bit         HAS_WAIT    = (WAIT_STATES > 0);
  localparam bit         RAZ_MODE    = (RESP_MODE == 1);
  // Wait counter counts down to zero, so W wait cycles load W-1 (W <= 15).
  localparam logic [3:0] WCNT_LOAD   = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  dflt_state_t state, state_nxt;
  logic [3:0]  wcnt, wcnt_nxt;
  htrans_t     htrans;
  logic        accept;

  // Only IDLE and ERR2 drive HREADY high, so only they can sample a new
  // address phase; inputs seen in WAIT/ERR1 are ignored.
  assign htrans = htrans_t'(HTRANS);
  assign accept = ((state == S_IDLE) || (state == S_ERR2)) &&
                  HSEL_DEFAULT && HREADY &&
                  ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  // State and wait-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state and wait-counter update.
  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      S_IDLE, S_ERR2: begin
        if (accept) begin
          if (HAS_WAIT) begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WCNT_LOAD;
          end else if (RAZ_MODE) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ERR1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt == 4'd0) begin
          state_nxt = RAZ_MODE ? S_IDLE : S_ERR1;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response outputs decode from the state register only.
  assign hready_default = (state == S_IDLE) || (state == S_ERR2);
  assign hresp_default  = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata_default = RAZ_MODE ? DEFAULT_RDATA : '0;
  assign hsplit_default = '0;

  ahb_fault_logger #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ID_WIDTH   (MASTER_ID_W),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_fault_logger (
    .clk        (HCLK),
    .rst        (HRESET),
    .accept     (accept),
    .clear      (err_clear),
    .addr       (HADDR),
    .master     (HMASTER),
    .write      (HWRITE),
    .err_valid  (err_valid),
    .err_addr   (err_addr),
    .err_master (err_master),
    .err_write  (err_write),
    .err_count  (err_count)
  );

endmodule

// File: tb/tb_ahb_default_slave_v2.sv
// Bench for ahb_default_slave_v2: three configurations (ERROR/no wait with a
// 2-bit counter, ERROR/3 waits, RAZ/no wait) share one driven bus; a
// response queue holds expected per-cycle outputs and a small log model
// tracks the fault registers.
`timescale 1ns/1ps
module tb_ahb_default_slave_v2;
  import ahb_params_pkg::*;

  localparam logic [31:0] RAZ_DATA = 32'hDEAD_BEEF;

  typedef struct {
    string       tag;
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        hsel_bus = 1'b0;
  logic        clear_bus = 1'b0;
  logic [1:0]  HTRANS = HTRANS_IDLE;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [1:0]  HMASTER = '0;
  logic [1:0]  active = 2'd0;
  logic        hready_bus;

  logic        hready_o [3];
  logic [1:0]  hresp_o  [3];
  logic [31:0] hrdata_o [3];
  logic [3:0]  hsplit_o [3];
  logic        valid_o  [3];
  logic [31:0] eaddr_o  [3];
  logic [1:0]  emst_o   [3];
  logic        ewr_o    [3];
  logic [1:0]  cnt0;
  logic [15:0] cnt1, cnt2;

  logic        mon_rdy, mon_valid, mon_wr;
  logic [1:0]  mon_resp, mon_mst;
  logic [31:0] mon_data, mon_addr;
  logic [3:0]  mon_split;
  logic [15:0] mon_cnt;

  int          cfg_wait  [3] = '{0, 3, 0};
  int          cfg_mode  [3] = '{0, 0, 1};
  int          cfg_max   [3] = '{3, 65535, 65535};
  logic [31:0] cfg_rdata [3] = '{32'h0, 32'h0, RAZ_DATA};

  int          m_cnt   [3];
  logic        m_valid [3];
  logic [31:0] m_addr  [3];
  logic [1:0]  m_mst   [3];
  logic        m_wr    [3];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_default_slave_v2 #(.WAIT_STATES(0), .RESP_MODE(0), .CNT_WIDTH(2)) u_dut_e0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_DEFAULT(hsel_bus && (active == 2'd0)),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HMASTER(HMASTER), .HREADY(hready_bus),
    .hrdata_default(hrdata_o[0]), .hready_default(hready_o[0]), .hresp_default(hresp_o[0]),
    .hsplit_default(hsplit_o[0]), .err_clear(clear_bus && (active == 2'd0)),
    .err_valid(valid_o[0]), .err_addr(eaddr_o[0]), .err_master(emst_o[0]),
    .err_write(ewr_o[0]), .err_count(cnt0));

  ahb_default_slave_v2 #(.WAIT_STATES(3), .RESP_MODE(0), .CNT_WIDTH(16)) u_dut_w3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_DEFAULT(hsel_bus && (active == 2'd1)),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HMASTER(HMASTER), .HREADY(hready_bus),
    .hrdata_default(hrdata_o[1]), .hready_default(hready_o[1]), .hresp_default(hresp_o[1]),
    .hsplit_default(hsplit_o[1]), .err_clear(clear_bus && (active == 2'd1)),
    .err_valid(valid_o[1]), .err_addr(eaddr_o[1]), .err_master(emst_o[1]),
    .err_write(ewr_o[1]), .err_count(cnt1));

  ahb_default_slave_v2 #(.WAIT_STATES(0), .RESP_MODE(1), .DEFAULT_RDATA(RAZ_DATA), .CNT_WIDTH(16)) u_dut_raz (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL_DEFAULT(hsel_bus && (active == 2'd2)),
    .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HMASTER(HMASTER), .HREADY(hready_bus),
    .hrdata_default(hrdata_o[2]), .hready_default(hready_o[2]), .hresp_default(hresp_o[2]),
    .hsplit_default(hsplit_o[2]), .err_clear(clear_bus && (active == 2'd2)),
    .err_valid(valid_o[2]), .err_addr(eaddr_o[2]), .err_master(emst_o[2]),
    .err_write(ewr_o[2]), .err_count(cnt2));

  // The selected slave's response drives bus HREADY, as the response mux would.
  always_comb begin
    case (active)
      2'd1: begin
        mon_rdy = hready_o[1]; mon_resp = hresp_o[1]; mon_data = hrdata_o[1]; mon_split = hsplit_o[1];
        mon_valid = valid_o[1]; mon_addr = eaddr_o[1]; mon_mst = emst_o[1]; mon_wr = ewr_o[1];
        mon_cnt = cnt1;
      end
      2'd2: begin
        mon_rdy = hready_o[2]; mon_resp = hresp_o[2]; mon_data = hrdata_o[2]; mon_split = hsplit_o[2];
        mon_valid = valid_o[2]; mon_addr = eaddr_o[2]; mon_mst = emst_o[2]; mon_wr = ewr_o[2];
        mon_cnt = cnt2;
      end
      default: begin
        mon_rdy = hready_o[0]; mon_resp = hresp_o[0]; mon_data = hrdata_o[0]; mon_split = hsplit_o[0];
        mon_valid = valid_o[0]; mon_addr = eaddr_o[0]; mon_mst = emst_o[0]; mon_wr = ewr_o[0];
        mon_cnt = {14'd0, cnt0};
      end
    endcase
  end
  assign hready_bus = mon_rdy;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic rdy, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    e.tag = tag; e.rdy = rdy; e.resp = resp; e.data = data;
    exp_q.push_back(e);
  endtask

  // One clock; compare the active slave's response against the queue head
  // (an empty queue means the slave should be idle: ready, OKAY).
  task automatic tick();
    exp_t e;
    @(posedge HCLK);
    @(negedge HCLK);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e.tag = "idle"; e.rdy = 1'b1; e.resp = HRESP_OKAY; e.data = cfg_rdata[active];
    end
    check({e.tag, "_hready"}, 64'(mon_rdy), 64'(e.rdy));
    check({e.tag, "_hresp"}, 64'(mon_resp), 64'(e.resp));
    check({e.tag, "_hrdata"}, 64'(mon_data), 64'(e.data));
    check({e.tag, "_hsplit"}, 64'(mon_split), 64'd0);
  endtask

  function automatic void log_capture(input int id, input logic [31:0] a, input logic [1:0] m, input logic w);
    m_addr[id] = a; m_mst[id] = m; m_wr[id] = w; m_valid[id] = 1'b1;
  endfunction

  // Drive one address phase at the negedge, record expectations, clock it.
  task automatic issue(input int id, input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                       input logic [1:0] mst, input logic clr, input string tag);
    bit acc;
    active = 2'(id);
    hsel_bus = 1'b1; HTRANS = trans; HADDR = addr; HWRITE = wr; HMASTER = mst; clear_bus = clr;
    acc = (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    if (acc) begin
      if (clr) begin
        m_cnt[id] = 1;
        log_capture(id, addr, mst, wr);
      end else begin
        if (m_cnt[id] < cfg_max[id]) m_cnt[id]++;
        if (!m_valid[id]) log_capture(id, addr, mst, wr);
      end
      for (int i = 0; i < cfg_wait[id]; i++) push({tag, "_wait"}, 1'b0, HRESP_OKAY, cfg_rdata[id]);
      if (cfg_mode[id] == 0) begin
        push({tag, "_err1"}, 1'b0, HRESP_ERROR, cfg_rdata[id]);
        push({tag, "_err2"}, 1'b1, HRESP_ERROR, cfg_rdata[id]);
      end else begin
        push({tag, "_okay"}, 1'b1, HRESP_OKAY, cfg_rdata[id]);
      end
    end else if (clr) begin
      m_cnt[id] = 0;
      m_valid[id] = 1'b0;
    end
    tick();
    hsel_bus = 1'b0; HTRANS = HTRANS_IDLE; clear_bus = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic check_log(input int id, input string tag);
    active = 2'(id);
    #1;
    check({tag, "_err_count"}, 64'(mon_cnt), 64'(m_cnt[id]));
    check({tag, "_err_valid"}, 64'(mon_valid), 64'(m_valid[id]));
    check({tag, "_err_addr"}, 64'(mon_addr), 64'(m_addr[id]));
    check({tag, "_err_master"}, 64'(mon_mst), 64'(m_mst[id]));
    check({tag, "_err_write"}, 64'(mon_wr), 64'(m_wr[id]));
  endtask

  function automatic void reset_models();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_valid[i] = 1'b0; m_addr[i] = '0; m_mst[i] = '0; m_wr[i] = 1'b0;
    end
  endfunction

  // Assert reset mid-cycle and confirm the response drops to idle at once.
  task automatic async_reset(input string tag);
    HRESET = 1'b1;
    #1;
    check({tag, "_hready"}, 64'(mon_rdy), 64'd1);
    check({tag, "_hresp"}, 64'(mon_resp), 64'(HRESP_OKAY));
    exp_q.delete();
    reset_models();
    for (int i = 0; i < 3; i++) check_log(i, tag);
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_models();
    #2 HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    check("rst_hready", 64'(mon_rdy), 64'd1);
    check("rst_hresp", 64'(mon_resp), 64'(HRESP_OKAY));
    for (int i = 0; i < 3; i++) check_log(i, "rst");
    @(negedge HCLK);
    HRESET = 1'b0;
    tick();

    // Zero-wait ERROR to an unmapped read.
    issue(0, HTRANS_NONSEQ, 32'hFFFF_0000, 1'b0, 2'd1, 1'b0, "s1");
    tick(); tick();
    check_log(0, "s1");

    // IDLE and BUSY while selected: zero-wait OKAY, not logged.
    issue(0, HTRANS_IDLE, 32'h1234_0000, 1'b1, 2'd3, 1'b0, "nacc_idle");
    issue(0, HTRANS_BUSY, 32'h1234_0004, 1'b1, 2'd3, 1'b0, "nacc_busy");
    check_log(0, "nacc");

    // Clear alone: counter and valid drop, capture holds.
    issue(0, HTRANS_IDLE, 32'h0, 1'b0, 2'd0, 1'b1, "clr");
    check_log(0, "clr");

    // Back-to-back faults accepted in ERR2.
    issue(0, HTRANS_NONSEQ, 32'hA000_0010, 1'b0, 2'd0, 1'b0, "b2b_a");
    tick();
    issue(0, HTRANS_SEQ, 32'hA000_0014, 1'b1, 2'd3, 1'b0, "b2b_b");
    tick();
    check_log(0, "b2b");

    // Saturation of the 2-bit counter, then clear coincident with a fault.
    for (int k = 0; k < 3; k++) begin
      issue(0, HTRANS_NONSEQ, 32'hB000_0000 + 32'(k * 4), 1'b0, 2'd1, 1'b0, "sat");
      tick();
    end
    check_log(0, "sat");
    issue(0, HTRANS_NONSEQ, 32'hB000_0100, 1'b1, 2'd2, 1'b1, "sat_clr");
    tick(); tick();
    check_log(0, "sat_clr");

    // Three wait states before the ERROR pair.
    issue(1, HTRANS_NONSEQ, 32'h4000_1234, 1'b1, 2'd2, 1'b0, "s2");
    drain();
    check_log(1, "s2");

    // RAZ/WI: zero-wait OKAY with the default read data, still logged.
    issue(2, HTRANS_NONSEQ, 32'h8000_0000, 1'b0, 2'd3, 1'b0, "s3");
    tick();
    check_log(2, "s3");
    issue(2, HTRANS_NONSEQ, 32'h8000_0100, 1'b1, 2'd1, 1'b0, "s3_wr");
    tick();
    check_log(2, "s3_wr");

    // Reset in the middle of the wait phase, then in ERR1.
    issue(1, HTRANS_NONSEQ, 32'h4000_2000, 1'b0, 2'd1, 1'b0, "s6_wait");
    tick();
    async_reset("rst_wait");
    issue(0, HTRANS_NONSEQ, 32'hC000_0000, 1'b1, 2'd0, 1'b0, "s6_err1");
    async_reset("rst_err1");

    // Normal behaviour after each reset.
    issue(0, HTRANS_NONSEQ, 32'hFFFF_0000, 1'b0, 2'd1, 1'b0, "post_s1");
    drain();
    check_log(0, "post_s1");
    issue(1, HTRANS_NONSEQ, 32'h4000_1234, 1'b1, 2'd2, 1'b0, "post_s2");
    drain();
    check_log(1, "post_s2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
